// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - KxK max/average pooling over a CxHxW map with a valid/ready output stream (optional POOL_RELU_EN)
module pool2d_stream #(
    parameter int DATA_W = 32,
    parameter int CH     = 32,
    parameter int IN_H   = 14,
    parameter int IN_W   = 14,
    parameter int K      = 2,
    parameter int OUT_H  = IN_H / K,
    parameter int OUT_W  = IN_W / K,
    parameter int ADDR_W = $clog2(CH * IN_H * IN_W),
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1,
    localparam int OH_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int OW_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic [OH_W-1:0]          out_row,
    output logic [OW_W-1:0]          out_col
);

    localparam int LOG_K = (K == 4) ? 2 : 1;
    localparam int KK    = K * K;
    localparam int SUM_W = DATA_W + 2 * LOG_K;
    localparam int CNT_W = $clog2(KK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic                       mode_q, mode_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [OH_W-1:0]            row_q, row_d;
    logic [OW_W-1:0]            col_q, col_d;
    // rd_cnt_q runs 0..KK-1 while reading and sits at KK for the capture-only cycle
    logic [CNT_W-1:0]           rd_cnt_q, rd_cnt_d;
    logic                       acc_vld_q;
    logic                       acc_first_q;
    logic signed [SUM_W-1:0]    acc_q;
    logic signed [SUM_W-1:0]    acc_n;
    logic signed [SUM_W-1:0]    sample_ext;
    logic signed [DATA_W-1:0]   out_data_q, out_data_d;
    logic signed [DATA_W-1:0]   pool_res;
    logic signed [DATA_W-1:0]   final_res;
    logic [LOG_K-1:0]           win_dx;
    logic [CNT_W-LOG_K-1:0]     win_dy;
    logic                       last_beat;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign out_valid = (state_q == S_EMIT);
    assign rd_en     = (state_q == S_FETCH) && (rd_cnt_q < CNT_W'(KK));
    assign out_data  = out_data_q;
    assign out_ch    = ch_q;
    assign out_row   = row_q;
    assign out_col   = col_q;

    // Window offset: dx is the low log2(K) bits of the read count, dy the rest
    assign win_dx = rd_cnt_q[LOG_K-1:0];
    assign win_dy = rd_cnt_q[CNT_W-1:LOG_K];

    // Flat buffer address of the current window element
    always_comb begin
        rd_addr = ADDR_W'(ch_q) * ADDR_W'(IN_H * IN_W)
                + (ADDR_W'(row_q) * ADDR_W'(K) + ADDR_W'(win_dy)) * ADDR_W'(IN_W)
                + ADDR_W'(col_q) * ADDR_W'(K) + ADDR_W'(win_dx);
    end

    // Fold the datum returned this cycle into the running max or sum
    always_comb begin
        sample_ext = {{(2 * LOG_K){rd_data[DATA_W-1]}}, rd_data};
        acc_n      = acc_q;
        if (acc_vld_q) begin
            if (acc_first_q) begin
                acc_n = sample_ext;
            end else if (mode_q) begin
                acc_n = acc_q + sample_ext;
            end else if (sample_ext > acc_q) begin
                acc_n = sample_ext;
            end
        end
    end

    // Average drops the low 2*log2(K) bits (floor toward -inf); max keeps the low DATA_W bits
    always_comb begin
        pool_res = mode_q ? acc_n[SUM_W-1:2*LOG_K] : acc_n[DATA_W-1:0];
`ifdef POOL_RELU_EN
        final_res = pool_res[DATA_W-1] ? '0 : pool_res;
`else
        final_res = pool_res;
`endif
    end

    assign last_beat = (ch_q == CH_W'(CH - 1)) && (row_q == OH_W'(OUT_H - 1))
                    && (col_q == OW_W'(OUT_W - 1));

    // Next-state and counter update for the pass sequencer
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ch_d       = ch_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_cnt_d   = rd_cnt_q;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    rd_cnt_d = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd_cnt_q == CNT_W'(KK)) begin
                    out_data_d = final_res;
                    state_d    = S_EMIT;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    rd_cnt_d = '0;
                    if (last_beat) begin
                        ch_d    = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FETCH;
                        if (col_q == OW_W'(OUT_W - 1)) begin
                            col_d = '0;
                            if (row_q == OH_W'(OUT_H - 1)) begin
                                row_d = '0;
                                ch_d  = ch_q + CH_W'(1);
                            end else begin
                                row_d = row_q + OH_W'(1);
                            end
                        end else begin
                            col_d = col_q + OW_W'(1);
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, position counters and the pooled result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            ch_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rd_cnt_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ch_q       <= ch_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_cnt_q   <= rd_cnt_d;
            out_data_q <= out_data_d;
        end
    end

    // Track which cycle carries read data back and whether it seeds the window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_vld_q   <= 1'b0;
            acc_first_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            acc_vld_q   <= rd_en;
            acc_first_q <= rd_en && (rd_cnt_q == '0);
            acc_q       <= acc_n;
        end
    end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
Parametrised 2-D pooling engine, successor to the fixed 32x14x14 2x2 max-pool stage in the CNN datapath. It reads a C x H x W feature map from a 1-cycle-latency buffer read port. It computes non-overlapping KxK max or average pooling (stride = K). Results leave on a valid/ready stream tagged with channel/row/col, so downstream dense/conv stages can apply backpressure.

Parameters:
DATA_W, 32, signed sample width
CH, 32, channel count
IN_H, 14, input height
IN_W, 14, input width
K, 2, window size and stride; legal values 2 or 4
OUT_H, IN_H/K (derived, floor), output height
OUT_W, IN_W/K (derived, floor), output width
ADDR_W, $clog2(CH*IN_H*IN_W), read address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  begin a pass; sampled only in IDLE
mode  in  1  0 = max, 1 = average; latched on accepted start
busy  out  1  high from accepted start until done pulse inclusive
done  out  1  one-cycle pulse after the last output beat is accepted
rd_en  out  1  read strobe to feature buffer
rd_addr  out  ADDR_W  c*IN_H*IN_W + r*IN_W + col
rd_data  in  DATA_W  signed; valid exactly 1 cycle after rd_en
out_valid  out  1  pooled sample valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  pooled value, signed
out_ch  out  $clog2(CH)  channel of out_data
out_row  out  $clog2(OUT_H)  output row
out_col  out  $clog2(OUT_W)  output column

Behaviour:
- Reset (reset==0, async): state IDLE, all counters 0. busy, done, rd_en and out_valid are 0. out_data/out_ch/out_row/out_col are 0. Mid-pass reset aborts immediately with no done pulse.
- FSM: IDLE -> FETCH on start. FETCH -> EMIT after last window datum is captured. EMIT -> FETCH (next window) or FINISH on out_valid&&out_ready. FINISH -> IDLE, with done=1 for that cycle.
- start while not IDLE is ignored. mode is held constant internally for the pass.
- FETCH: K*K consecutive cycles with rd_en=1, scanning window row-major (dy outer, dx inner). Data is accumulated the cycle after each read. The window base is (r*K, col*K).
- Max: running max, seeded with the first datum; signed compare; ties keep the earlier value.
- Average: sum in DATA_W+2*log2(K) bits signed. Result = sum >>> log2(K*K), i.e. arithmetic shift, floor toward -inf. Truncate to DATA_W (always fits).
- Output: out_valid rises the cycle after the last datum arrives. Latency from first rd_en to out_valid = K*K+1 cycles.
- out_valid and all out_* fields hold stable until accepted. No reads are issued while out_valid && !out_ready.
- Scan order: col fastest, then row, then channel. Total CH*OUT_H*OUT_W beats per pass.
- Odd remainders: trailing IN_H%K rows and IN_W%K columns are never read.
- Wrap: after (CH-1, OUT_H-1, OUT_W-1) is accepted, go to FINISH. Counters reset to 0.
- done and a new start never overlap. start is accepted at earliest the cycle after done.

Optional Feature:
POOL_RELU_EN:
- Defined: out_data = (result < 0) ? 0 : result. Applied after max/avg, same cycle; no latency change.
- Undefined: out_data is the raw signed result.

Test Plan:
- CH=1, IN 4x4, K=2, max, map values 0..15 row-major, out_ready=1 -> beats 5,7,13,15 in order. done pulses once, 1 cycle after beat 4. 4*(4+1+1)-cycle-range timing is checked.
- Same map, mode=1 -> 2,4,10,12 (sums 10,18,42,50 >>>2).
- Window {-1,-2,-3,-5}, average -> sum -11 >>>2 = -3. With POOL_RELU_EN -> 0. Max -> -1 (0 with POOL_RELU_EN).
- Default params, out_ready toggles 1-of-3 cycles: 32*7*7=1568 beats with correct ch/row/col. out_* are stable while stalled, and rd_en stays 0 during stalls.
- IN 5x5, K=2: exactly 4 beats. rd_addr never touches row 4 or col 4.
- reset driven low mid-FETCH of beat 3: all outputs are 0 immediately, with no done. A new start after release restarts at ch0/row0/col0.
